ram_dual_port: RTL and testbench
================================

# ram_dual_port

Parametrised simple dual-port RAM (one write port, one read port) with per-lane write masking, a registered read with valid flag, and a hardware clear sequencer that zeroes every word after reset or on request. It succeeds the single-port 1-bit RAM as the general storage primitive for buffers, register files and lookup tables. It is self-initialising: consumers wait on `ready` instead of relying on simulator initial values.

## Interface
Parameters:
- `ADDRESS_BITS`, default 4: address width; depth is `DEPTH = 2**ADDRESS_BITS`.
- `DATA_BITS`, default 8: word width.
- `LANES`, default 1: number of write-mask lanes. `DATA_BITS % LANES` must be 0. Lane width is `DATA_BITS/LANES`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous request to re-zero the whole array.
- `write`  in  1  write strobe.
- `write_mask`  in  LANES  lane enables; bit i covers data bits [i*LW +: LW].
- `write_address`  in  ADDRESS_BITS  write address.
- `data_in`  in  DATA_BITS  write data.
- `read`  in  1  read strobe.
- `read_address`  in  ADDRESS_BITS  read address.
- `data_out`  out  DATA_BITS  registered read data.
- `read_valid`  out  1  `data_out` was updated by the previous edge's read.
- `ready`  out  1  array is initialised; writes and reads are accepted.

## Operation
- FSM states: CLEAR and READY. Asserting `reset` forces CLEAR, with the clear counter at 0, `ready`=0, `read_valid`=0 and `data_out`=0. The array contents are not reset directly.
- CLEAR: on each edge, writes 0 to word `clear_counter`, then increments the counter. The edge that writes word DEPTH-1 moves the FSM to READY.
- In CLEAR, `write`, `read` and `clear` are ignored. `read_valid` stays 0 and `data_out` holds its value.
- READY, write: when `write`=1, each lane i with `write_mask[i]`=1 takes its slice of `data_in`. Unmasked lanes keep their old value. A mask of all zeros writes nothing.
- READY, read: when `read`=1, the next edge loads `data_out` with word `read_address` and sets `read_valid`=1. When `read`=0, `read_valid`=0 and `data_out` holds.
- Same-address read and write on the same edge: the read is read-first, so `data_out` returns the pre-write word.
- READY with `clear`=1: enters CLEAR with the counter at 0. A `write` or `read` on that same edge is ignored.

## Timing
- Clear duration: exactly DEPTH edges. `ready` rises after the DEPTH-th rising edge following `reset` deassertion, and stays 0 throughout.
- Read latency: 1 cycle from a sampled `read` to `data_out`/`read_valid`.
- Write-to-read latency: a write at edge N is visible to a read sampled at edge N+1.
- `reset` mid-clear or mid-operation: outputs clear immediately and asynchronously. The clear restarts from word 0 after release.
- `clear` asserted again while in CLEAR: no effect; the clear is not restarted.
- Counter wrap: the clear counter is ADDRESS_BITS+1 wide, or uses an explicit last-word compare, so that DEPTH=2 and ADDRESS_BITS=1 terminate correctly.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset release, default parameters: `ready`=0 for 16 edges, then 1. Reading all 16 addresses gives `data_out`=0x00, each with `read_valid`=1 one cycle after its `read`.
- Masked write, LANES=2, DATA_BITS=8: write 0xAB to addr 3 with mask 2'b11, then 0x5C with mask 2'b01 → a read of addr 3 returns 0xAC. Then write with mask 2'b00 → the read still returns 0xAC.
- Same-address collision: addr 5 holds 0x11; write 0x22 and read addr 5 on the same edge → `data_out`=0x11; the next read returns 0x22.
- `clear` in READY: fill addr 0..15 with their index, assert `clear` together with a write of 0xFF to addr 0 → `ready` is low for 16 edges, and all reads afterwards return 0.
- Reset mid-clear: assert `reset` asynchronously during clear edge 7 → `ready`, `read_valid` and `data_out` go to 0 at once. After release, the full 16-edge clear is observed again.
- Minimal configuration, ADDRESS_BITS=1 and DATA_BITS=1 → `ready` rises after 2 edges; write 1 to addr 0 → the read returns 1 and addr 1 reads 0.

Source files
------------

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one masked write port, one registered read port with valid flag,
// and a self-clearing sequencer that zeroes every word after reset or on request.
module ram_dual_port #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_BITS    = 8,
  parameter int LANES        = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    write,
  input  logic [LANES-1:0]        write_mask,
  input  logic [ADDRESS_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0]    data_in,
  input  logic                    read,
  input  logic [ADDRESS_BITS-1:0] read_address,
  output logic [DATA_BITS-1:0]    data_out,
  output logic                    read_valid,
  output logic                    ready
);

  localparam int DEPTH     = 2 ** ADDRESS_BITS;
  localparam int LANE_BITS = DATA_BITS / LANES;
  localparam logic [ADDRESS_BITS-1:0] LAST_WORD = ADDRESS_BITS'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] clear_counter;
  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic                    accept;

  // A clear request in READY takes priority over any read or write on the same edge.
  assign accept = (state == ST_READY) && !clear;

  // Storage has no reset; the clear sequencer owns it while not ready.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clear_counter] <= '0;
    end else if (accept && write) begin
      for (int i = 0; i < LANES; i++) begin
        if (write_mask[i]) begin
          mem[write_address][i*LANE_BITS +: LANE_BITS] <= data_in[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  // Last-word compare ends the sweep, so the counter never needs an extra bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_CLEAR;
      clear_counter <= '0;
      ready         <= 1'b0;
      read_valid    <= 1'b0;
      data_out      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          read_valid    <= 1'b0;
          clear_counter <= clear_counter + ADDRESS_BITS'(1);
          if (clear_counter == LAST_WORD) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (clear) begin
            state         <= ST_CLEAR;
            clear_counter <= '0;
            ready         <= 1'b0;
            read_valid    <= 1'b0;
          end else begin
            read_valid <= read;
            if (read) begin
              data_out <= mem[read_address];
            end
          end
        end
        default: begin
          state         <= ST_CLEAR;
          clear_counter <= '0;
          ready         <= 1'b0;
          read_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dual_port.sv
// Self-checking bench for ram_dual_port: a 16x8 two-lane instance against an array-based
// reference model, plus a minimal 2x1 instance exercised by hand.
module tb_ram_dual_port;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       write = 1'b0;
  logic [1:0] write_mask = 2'b00;
  logic [3:0] write_address = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       read = 1'b0;
  logic [3:0] read_address = 4'd0;
  logic [7:0] data_out;
  logic       read_valid;
  logic       ready;

  logic       min_clear = 1'b0;
  logic       min_write = 1'b0;
  logic [0:0] min_write_mask = 1'b0;
  logic [0:0] min_write_address = 1'b0;
  logic [0:0] min_data_in = 1'b0;
  logic       min_read = 1'b0;
  logic [0:0] min_read_address = 1'b0;
  logic [0:0] min_data_out;
  logic       min_read_valid;
  logic       min_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [DEPTH];
  bit         ref_ready = 1'b0;
  int         ref_count = 0;
  logic [7:0] ref_dout = 8'd0;
  bit         ref_valid = 1'b0;

  typedef struct {
    bit         wr;
    logic [1:0] mask;
    logic [3:0] wa;
    logic [7:0] din;
    bit         rd;
    logic [3:0] ra;
    logic [7:0] exp_dout;
    bit         exp_valid;
  } vec_t;

  vec_t vectors [10];

  ram_dual_port #(.ADDRESS_BITS(4), .DATA_BITS(8), .LANES(2)) dut (
    .clock(clock), .reset(reset), .clear(clear), .write(write),
    .write_mask(write_mask), .write_address(write_address), .data_in(data_in),
    .read(read), .read_address(read_address), .data_out(data_out),
    .read_valid(read_valid), .ready(ready)
  );

  ram_dual_port #(.ADDRESS_BITS(1), .DATA_BITS(1), .LANES(1)) dut_min (
    .clock(clock), .reset(reset), .clear(min_clear), .write(min_write),
    .write_mask(min_write_mask), .write_address(min_write_address), .data_in(min_data_in),
    .read(min_read), .read_address(min_read_address), .data_out(min_data_out),
    .read_valid(min_read_valid), .ready(min_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] lane_bits(input logic [1:0] m);
    return {{4{m[1]}}, {4{m[0]}}};
  endfunction

  // Reference behaviour for one rising edge, taken from the block's rules.
  task automatic model_step();
    logic [7:0] bm;
    if (!ref_ready) begin
      ref_mem[ref_count] = 8'd0;
      ref_count++;
      ref_valid = 1'b0;
      if (ref_count == DEPTH) begin
        ref_ready = 1'b1;
        ref_count = 0;
      end
    end else if (clear) begin
      ref_ready = 1'b0;
      ref_count = 0;
      ref_valid = 1'b0;
    end else begin
      if (read) begin
        ref_dout  = ref_mem[read_address];
        ref_valid = 1'b1;
      end else begin
        ref_valid = 1'b0;
      end
      if (write) begin
        bm = lane_bits(write_mask);
        ref_mem[write_address] = (ref_mem[write_address] & ~bm) | (data_in & bm);
      end
    end
  endtask

  task automatic model_reset();
    ref_ready = 1'b0;
    ref_count = 0;
    ref_dout  = 8'd0;
    ref_valid = 1'b0;
  endtask

  task automatic checkOutput();
    check("ready", 32'(ready), 32'(ref_ready));
    check("read_valid", 32'(read_valid), 32'(ref_valid));
    check("data_out", 32'(data_out), 32'(ref_dout));
  endtask

  task automatic applyStimulus(input bit wr, input logic [1:0] m, input logic [3:0] wa,
                               input logic [7:0] d, input bit rd, input logic [3:0] ra,
                               input bit clr);
    write = wr; write_mask = m; write_address = wa; data_in = d;
    read = rd; read_address = ra; clear = clr;
    @(posedge clock);
    model_step();
    #1;
    checkOutput();
    write = 1'b0; write_mask = 2'b00; read = 1'b0; clear = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic count_clear(input string name);
    for (int e = 1; e <= DEPTH; e++) begin
      idle();
      check(name, 32'(ready), 32'(e == DEPTH));
    end
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 2'b00, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0);
      check("read_zero_data", 32'(data_out), 32'd0);
      check("read_zero_valid", 32'(read_valid), 32'd1);
    end
  endtask

  task automatic fill_index();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 2'b11, 4'(a), 8'(a), 1'b0, 4'd0, 1'b0);
    end
  endtask

  initial begin
    vectors[0] = '{1'b1, 2'b11, 4'd3, 8'hAB, 1'b0, 4'd0, 8'h00, 1'b0};
    vectors[1] = '{1'b1, 2'b01, 4'd3, 8'h5C, 1'b0, 4'd0, 8'h00, 1'b0};
    vectors[2] = '{1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd3, 8'hAC, 1'b1};
    vectors[3] = '{1'b1, 2'b00, 4'd3, 8'hFF, 1'b0, 4'd0, 8'h00, 1'b0};
    vectors[4] = '{1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd3, 8'hAC, 1'b1};
    vectors[5] = '{1'b1, 2'b11, 4'd5, 8'h11, 1'b0, 4'd0, 8'h00, 1'b0};
    vectors[6] = '{1'b1, 2'b11, 4'd5, 8'h22, 1'b1, 4'd5, 8'h11, 1'b1};
    vectors[7] = '{1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd5, 8'h22, 1'b1};
    vectors[8] = '{1'b1, 2'b10, 4'd3, 8'h70, 1'b1, 4'd3, 8'hAC, 1'b1};
    vectors[9] = '{1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 4'd3, 8'h7C, 1'b1};

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput();
    check("min_ready_reset", 32'(min_ready), 32'd0);
    reset = 1'b0;

    for (int e = 1; e <= DEPTH; e++) begin
      idle();
      check("ready_after_reset", 32'(ready), 32'(e == DEPTH));
      check("min_ready_after_reset", 32'(min_ready), 32'(e >= 2));
    end
    read_all_zero();

    min_write = 1'b1; min_write_mask = 1'b1; min_write_address = 1'b0; min_data_in = 1'b1;
    idle();
    min_write = 1'b0; min_read = 1'b1; min_read_address = 1'b0;
    idle();
    check("min_read_addr0", 32'(min_data_out), 32'd1);
    check("min_valid_addr0", 32'(min_read_valid), 32'd1);
    min_read_address = 1'b1;
    idle();
    check("min_read_addr1", 32'(min_data_out), 32'd0);
    min_read = 1'b0;
    idle();
    check("min_valid_idle", 32'(min_read_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].wr, vectors[i].mask, vectors[i].wa, vectors[i].din,
                    vectors[i].rd, vectors[i].ra, 1'b0);
      check("vec_valid", 32'(read_valid), 32'(vectors[i].exp_valid));
      if (vectors[i].exp_valid) check("vec_data", 32'(data_out), 32'(vectors[i].exp_dout));
    end

    // Clear request alongside a write: the write must be dropped.
    fill_index();
    applyStimulus(1'b1, 2'b11, 4'd0, 8'hFF, 1'b1, 4'd7, 1'b1);
    check("ready_on_clear_edge", 32'(ready), 32'd0);
    count_clear("ready_after_clear");
    read_all_zero();

    // Asynchronous reset partway through a clear sweep.
    fill_index();
    applyStimulus(1'b0, 2'b00, 4'd0, 8'd0, 1'b1, 4'd9, 1'b0);
    check("read_before_clear", 32'(data_out), 32'd9);
    applyStimulus(1'b0, 2'b00, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
    for (int e = 1; e <= 7; e++) idle();
    check("data_held_in_clear", 32'(data_out), 32'd9);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_data", 32'(data_out), 32'd0);
    check("async_reset_ready", 32'(ready), 32'd0);
    check("async_reset_valid", 32'(read_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    count_clear("ready_after_reset_release");
    read_all_zero();

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
